// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter for the shared register-file write port
//
// Two writeback requesters (0 = ALU, 1 = load/multi-cycle unit) compete for the
// single register-file write port. The winner is chosen combinationally and
// its write is registered onto A3/WD3/WE3 one cycle later.
//
// Ports:
//   CLK, RST                    clock, asynchronous active-high reset
//   HOLD                        pipeline freeze, no grants while high
//   REQ_VALIDi/ADDRi/DATAi      requester i pending write
//   REQ_READYi                  requester i accepted this cycle
//   A3, WD3, WE3                registered register-file write port
//   PRIO                        round-robin pointer (requester favoured on contention)
//   STALL_CNT                   saturating count of cycles with a stalled requester

module regfile_write_arbiter #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int CNT_BITS  = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 HOLD,
    input  logic                 REQ_VALID0,
    input  logic [ADDR_BITS-1:0] REQ_ADDR0,
    input  logic [WIDTH-1:0]     REQ_DATA0,
    output logic                 REQ_READY0,
    input  logic                 REQ_VALID1,
    input  logic [ADDR_BITS-1:0] REQ_ADDR1,
    input  logic [WIDTH-1:0]     REQ_DATA1,
    output logic                 REQ_READY1,
    output logic [ADDR_BITS-1:0] A3,
    output logic [WIDTH-1:0]     WD3,
    output logic                 WE3,
    output logic                 PRIO,
    output logic [CNT_BITS-1:0]  STALL_CNT
);

    logic                 contested;
    logic                 xfer0;
    logic                 xfer1;
    logic                 stall;
    logic [ADDR_BITS-1:0] win_addr;
    logic [WIDTH-1:0]     win_data;

    // Grant: a lone requester always wins; under contention PRIO decides.
    // RST masks both grants so nothing handshakes while the port is held in reset.
    always_comb begin
        REQ_READY0 = 1'b0;
        REQ_READY1 = 1'b0;
        if (!RST && !HOLD) begin
            REQ_READY0 = REQ_VALID0 && (!REQ_VALID1 || !PRIO);
            REQ_READY1 = REQ_VALID1 && (!REQ_VALID0 ||  PRIO);
        end
    end

    always_comb begin
        contested = REQ_VALID0 && REQ_VALID1 && !HOLD;
        xfer0     = REQ_VALID0 && REQ_READY0;
        xfer1     = REQ_VALID1 && REQ_READY1;
        // Both stalled in one cycle still counts once.
        stall     = (REQ_VALID0 && !REQ_READY0) || (REQ_VALID1 && !REQ_READY1);
        win_addr  = xfer1 ? REQ_ADDR1 : REQ_ADDR0;
        win_data  = xfer1 ? REQ_DATA1 : REQ_DATA0;
    end

    // The winner of a contested cycle is PRIO, so handing priority to the loser
    // is simply a toggle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PRIO <= 1'b0;
        end else if (contested) begin
            PRIO <= ~PRIO;
        end
    end

    // Writes to register 0 complete the handshake and update A3/WD3 but keep WE3 low.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            A3  <= '0;
            WD3 <= '0;
            WE3 <= 1'b0;
        end else if (xfer0 || xfer1) begin
            A3  <= win_addr;
            WD3 <= win_data;
            WE3 <= (win_addr != '0);
        end else begin
            WE3 <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            STALL_CNT <= '0;
        end else if (stall && (STALL_CNT != {CNT_BITS{1'b1}})) begin
            STALL_CNT <= STALL_CNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter

module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst;
    logic        hold;
    logic        v0, v1;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic        r0, r1;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        we3;
    logic        prio;
    logic [15:0] stall_cnt;

    logic        s_hold;
    logic        s_v0;
    logic        s_r0, s_r1;
    logic [4:0]  s_a3;
    logic [31:0] s_wd3;
    logic        s_we3;
    logic        s_prio;
    logic [3:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    regfile_write_arbiter #(.WIDTH(32), .ADDR_BITS(5), .CNT_BITS(16)) dut (
        .CLK(clk), .RST(rst), .HOLD(hold),
        .REQ_VALID0(v0), .REQ_ADDR0(a0), .REQ_DATA0(d0), .REQ_READY0(r0),
        .REQ_VALID1(v1), .REQ_ADDR1(a1), .REQ_DATA1(d1), .REQ_READY1(r1),
        .A3(a3), .WD3(wd3), .WE3(we3), .PRIO(prio), .STALL_CNT(stall_cnt)
    );

    regfile_write_arbiter #(.WIDTH(32), .ADDR_BITS(5), .CNT_BITS(4)) dut_sat (
        .CLK(clk), .RST(rst), .HOLD(s_hold),
        .REQ_VALID0(s_v0), .REQ_ADDR0(5'd1), .REQ_DATA0(32'h1), .REQ_READY0(s_r0),
        .REQ_VALID1(1'b0), .REQ_ADDR1(5'd0), .REQ_DATA1(32'h0), .REQ_READY1(s_r1),
        .A3(s_a3), .WD3(s_wd3), .WE3(s_we3), .PRIO(s_prio), .STALL_CNT(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0;
        v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        s_hold = 1'b1; s_v0 = 1'b1;

        // Reset with both requesters valid, before any clock edge
        #2;
        v0 = 1'b1; a0 = 5'd3; d0 = 32'h11;
        v1 = 1'b1; a1 = 5'd7; d1 = 32'h22;
        #1;
        chk("rst_ready0", r0, 1'b0);
        chk("rst_ready1", r1, 1'b0);
        chk("rst_we3", we3, 1'b0);
        chk("rst_prio", prio, 1'b0);
        chk("rst_cnt", stall_cnt, 16'd0);
        chk("rst_a3", a3, 5'd0);
        chk("rst_wd3", wd3, 32'd0);
        repeat (2) tick();
        chk("rst_hold_cnt", stall_cnt, 16'd0);
        chk("rst_hold_we3", we3, 1'b0);

        // Release: contention, grants 0,1,0 then requester 1 alone
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("c1_ready0", r0, 1'b1);
        chk("c1_ready1", r1, 1'b0);
        tick();
        chk("c1_we3", we3, 1'b1);
        chk("c1_a3", a3, 5'd3);
        chk("c1_wd3", wd3, 32'h11);
        chk("c1_prio", prio, 1'b1);
        chk("c1_cnt", stall_cnt, 16'd1);
        chk("c2_ready0", r0, 1'b0);
        chk("c2_ready1", r1, 1'b1);
        tick();
        chk("c2_we3", we3, 1'b1);
        chk("c2_a3", a3, 5'd7);
        chk("c2_wd3", wd3, 32'h22);
        chk("c2_prio", prio, 1'b0);
        chk("c2_cnt", stall_cnt, 16'd2);
        chk("c3_ready0", r0, 1'b1);
        chk("c3_ready1", r1, 1'b0);
        tick();
        chk("c3_we3", we3, 1'b1);
        chk("c3_a3", a3, 5'd3);
        chk("c3_prio", prio, 1'b1);
        chk("c3_cnt", stall_cnt, 16'd3);
        v0 = 1'b0;
        #1;
        chk("c4_ready1", r1, 1'b1);
        tick();
        // Cycle 4 is uncontested: no stall, pointer unchanged
        chk("c4_we3", we3, 1'b1);
        chk("c4_a3", a3, 5'd7);
        chk("c4_wd3", wd3, 32'h22);
        chk("c4_prio", prio, 1'b1);
        chk("c4_cnt", stall_cnt, 16'd3);
        v1 = 1'b0;
        tick();
        chk("c5_we3", we3, 1'b0);
        chk("c5_a3_hold", a3, 5'd7);

        // Fresh reset, then single requester 1
        rst = 1'b1;
        #2;
        rst = 1'b0;
        chk("mid_prio", prio, 1'b0);
        v1 = 1'b1; a1 = 5'd5; d1 = 32'hDEADBEEF;
        #1;
        chk("s_ready1", r1, 1'b1);
        chk("s_ready0", r0, 1'b0);
        tick();
        v1 = 1'b0;
        chk("s_we3", we3, 1'b1);
        chk("s_a3", a3, 5'd5);
        chk("s_wd3", wd3, 32'hDEADBEEF);
        tick();
        chk("s_we3_off", we3, 1'b0);
        chk("s_prio", prio, 1'b0);

        // Register 0 write is accepted but not issued
        v0 = 1'b1; a0 = 5'd0; d0 = 32'h55;
        #1;
        chk("z_ready0", r0, 1'b1);
        tick();
        v0 = 1'b0;
        chk("z_we3", we3, 1'b0);
        chk("z_a3", a3, 5'd0);
        chk("z_wd3", wd3, 32'h55);
        chk("z_cnt", stall_cnt, 16'd0);

        // HOLD for three cycles
        hold = 1'b1; v0 = 1'b1; a0 = 5'd9; d0 = 32'hAB;
        #1;
        chk("h_ready0", r0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("h_we3", we3, 1'b0);
        end
        chk("h_cnt", stall_cnt, 16'd3);
        hold = 1'b0;
        #1;
        chk("h_ready0_rel", r0, 1'b1);
        tick();
        chk("h_we3_rel", we3, 1'b1);
        chk("h_a3", a3, 5'd9);
        chk("h_wd3", wd3, 32'hAB);
        chk("h_cnt_rel", stall_cnt, 16'd3);

        // Asynchronous reset with WE3 high clears it at once
        a0 = 5'd4; d0 = 32'h44;
        #1;
        rst = 1'b1;
        #1;
        chk("ar_we3", we3, 1'b0);
        chk("ar_ready0", r0, 1'b0);
        chk("ar_cnt", stall_cnt, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ar_ready0_rel", r0, 1'b1);
        tick();
        v0 = 1'b0;
        chk("ar_we3_rel", we3, 1'b1);
        chk("ar_a3", a3, 5'd4);
        chk("ar_wd3", wd3, 32'h44);

        // Saturation on the 4-bit counter instance, held stalled by its HOLD
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("sat_rst", s_cnt, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_14", s_cnt, 4'd14);
        tick();
        chk("sat_15", s_cnt, 4'd15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_hold15", s_cnt, 4'd15);
        chk("sat_ready", s_r0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
